// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared BTB entry type and counter encodings for the branch predictor
package bp_pkg;

    localparam int BP_IDX_W_DEF = 4;
    // Tag field sized for the narrowest legal index (IDX_W=0); narrower tags are zero-extended.
    localparam int TAG_MAX_W    = 14;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [1:0] CTR_RST = CTR_WNT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [15:0]          target;
        logic [1:0]           ctr;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next-state logic for a 2-bit saturating direction counter
import bp_pkg::*;

module sat_counter2 (
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (inc) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; BP_STATS_EN adds branch/mispredict counters
import bp_pkg::*;

module branch_predictor #(
    parameter int IDX_W = BP_IDX_W_DEF,
    parameter int TAG_W = 16 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_DONE,
    input  logic        MEM_DONE,
    input  logic [31:0] pc,
    output logic        pTaken,
    output logic [15:0] pTarget,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [15:0] upd_pred_target,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        mispredict
);

    localparam int NENT = 2 ** IDX_W;

    bp_entry_t table_q [NENT];

    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic                 lk_hit;
    bp_entry_t            lk_entry;

    logic [IDX_W-1:0]     up_idx;
    logic [TAG_MAX_W-1:0] up_tag;
    logic                 up_hit;
    logic                 up_accept;
    logic                 up_in_range;
    bp_entry_t            up_entry;
    logic [1:0]           up_ctr_nxt;
    logic                 unused_upd_pc_lsbs;

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    // Lookup: combinational read of the pre-update table, no write bypass.
    assign lk_idx   = pc[IDX_W+1:2];
    assign lk_tag   = TAG_MAX_W'(pc[15:IDX_W+2]);
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag)
                      && (pc[31:16] == 16'd0) && (pc[1:0] == 2'b00);
    assign pTaken   = lk_hit && lk_entry.ctr[1];
    assign pTarget  = lk_hit ? lk_entry.target : 16'd0;

    assign mispredict = upd_valid && ((upd_pred_taken != upd_taken)
                        || (upd_taken && (upd_pred_target != upd_target)));

    assign up_idx      = upd_pc[IDX_W+1:2];
    assign up_tag      = TAG_MAX_W'(upd_pc[15:IDX_W+2]);
    assign up_entry    = table_q[up_idx];
    assign up_hit      = up_entry.valid && (up_entry.tag == up_tag);
    assign up_accept   = upd_valid && IF_DONE && MEM_DONE;
    assign up_in_range = (upd_pc[31:16] == 16'd0);

    sat_counter2 u_ctr (
        .ctr     (up_entry.ctr),
        .inc     (upd_taken),
        .ctr_nxt (up_ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= 16'd0;
                table_q[i].ctr    <= CTR_RST;
            end
        end else if (up_accept && up_in_range) begin
            if (up_hit) begin
                table_q[up_idx].ctr <= up_ctr_nxt;
                if (upd_taken) table_q[up_idx].target <= upd_target;
            end else if (upd_taken) begin
                // Taken miss evicts whatever alias occupies this slot.
                table_q[up_idx].valid  <= 1'b1;
                table_q[up_idx].tag    <= up_tag;
                table_q[up_idx].target <= upd_target;
                table_q[up_idx].ctr    <= CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (up_accept) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

    // TAG_W documents the effective tag width; storage uses the package-wide field.
    logic unused_tag_w;
    assign unused_tag_w = (TAG_W > TAG_MAX_W);

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a behavioural BTB model
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_DONE, MEM_DONE;
    logic [31:0] pc;
    logic        pTaken;
    logic [15:0] pTarget;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: 16 slots, counter kept as an integer 0..3.
    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_ctr   [16];
    longint m_branches, m_mispredicts;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .IF_DONE         (IF_DONE),
        .MEM_DONE        (MEM_DONE),
        .pc              (pc),
        .pTaken          (pTaken),
        .pTarget         (pTarget),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
`ifdef BP_STATS_EN
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .mispredict      (mispredict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_branches   = 0;
        m_mispredicts = 0;
    endtask

    task automatic check_lookup(input string tag);
        int  i, t;
        bit  hit;
        i   = (pc >> 2) % 16;
        t   = (pc >> 6) & 32'h3FF;
        hit = m_valid[i] && (m_tag[i] == t) && (pc[31:16] == 0) && (pc[1:0] == 0);
        check({tag, ".pTaken"},  {31'd0, pTaken},  {31'd0, hit && (m_ctr[i] >= 2)});
        check({tag, ".pTarget"}, {16'd0, pTarget}, hit ? m_tgt[i] : 0);
    endtask

    // One update attempt; pc follows upd_pc so the same-cycle lookup is observed pre-update.
    task automatic do_update(input logic [31:0] p, input logic tk, input logic [15:0] tg,
                             input logic ptk, input logic [15:0] ptg,
                             input logic ifd, input logic memd, input string tag);
        int i, t;
        bit misp;
        upd_valid = 1; upd_pc = p; upd_taken = tk; upd_target = tg;
        upd_pred_taken = ptk; upd_pred_target = ptg;
        IF_DONE = ifd; MEM_DONE = memd; pc = p;
        misp = (ptk != tk) || (tk && ptg != tg);
        #1;
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, misp});
        check_lookup({tag, ".pre"});
        @(posedge clk);
        if (ifd && memd) begin
            if (m_branches < 64'hFFFF_FFFF) m_branches++;
            if (misp && m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
            if (p[31:16] == 0) begin
                i = (p >> 2) % 16;
                t = (p >> 6) & 32'h3FF;
                if (m_valid[i] && m_tag[i] == t) begin
                    if (tk) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = tg;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (tk) begin
                    m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tg; m_ctr[i] = 2;
                end
            end
        end
        #1;
        upd_valid = 0; IF_DONE = 1; MEM_DONE = 1;
        #1;
        check_lookup({tag, ".post"});
    endtask

    task automatic apply_reset();
        rst = 1;
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 16'h1234;
        IF_DONE = 1; MEM_DONE = 1;
        @(posedge clk);
        #1;
        rst = 0; upd_valid = 0;
        model_reset();
    endtask

    logic [31:0] rp;
    logic [15:0] rt;

    initial begin
        rst = 1; IF_DONE = 1; MEM_DONE = 1; pc = 32'h40;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_pred_taken = 0; upd_pred_target = 0;
        apply_reset();

        #1;
        check("rst.pTaken",  {31'd0, pTaken}, 32'd0);
        check("rst.pTarget", {16'd0, pTarget}, 32'd0);
        check("rst.mispredict_idle", {31'd0, mispredict}, 32'd0);
`ifdef BP_STATS_EN
        check("rst.stat_branches", stat_branches, 32'd0);
        check("rst.stat_mispredicts", stat_mispredicts, 32'd0);
`endif

        do_update(32'h40, 1, 16'h100, 0, 16'h0, 1, 1, "alloc40");
        pc = 32'h40; #1;
        check("alloc40.taken",  {31'd0, pTaken},  32'd1);
        check("alloc40.target", {16'd0, pTarget}, 32'h100);

        do_update(32'h40, 0, 16'h0, 1, 16'h100, 1, 1, "nt1");
        pc = 32'h40; #1;
        check("nt1.taken",  {31'd0, pTaken},  32'd0);
        check("nt1.target", {16'd0, pTarget}, 32'h100);
        do_update(32'h40, 0, 16'h0, 0, 16'h0, 1, 1, "nt2");
        for (int k = 0; k < 4; k++) do_update(32'h40, 1, 16'h200, 0, 16'h0, 1, 1, "tk_sat");
        // From saturated strong-taken, one not-taken still predicts taken, a second does not.
        do_update(32'h40, 0, 16'h0, 1, 16'h200, 1, 1, "dec_from_st");
        pc = 32'h40; #1;
        check("sat.still_taken", {31'd0, pTaken}, 32'd1);
        do_update(32'h40, 0, 16'h0, 1, 16'h200, 1, 1, "dec_to_wnt");
        pc = 32'h40; #1;
        check("sat.now_not_taken", {31'd0, pTaken}, 32'd0);

        do_update(32'h80, 1, 16'h300, 0, 16'h0, 1, 1, "alias80");
        pc = 32'h40; #1;
        check("evict.pc40", {31'd0, pTaken}, 32'd0);
        pc = 32'h80; #1;
        check("evict.pc80", {16'd0, pTarget}, 32'h300);

        do_update(32'h0C, 1, 16'h0AA, 0, 16'h0, 0, 1, "if_low");
        do_update(32'h0C, 1, 16'h0AA, 0, 16'h0, 1, 0, "mem_low");
        pc = 32'h0C; #1;
        check("done_low.no_alloc", {31'd0, pTaken}, 32'd0);
        do_update(32'h0001_0040, 1, 16'h0BB, 0, 16'h0, 1, 1, "hi_pc");
        pc = 32'h0001_0040; #1;
        check("hi_pc.taken", {31'd0, pTaken}, 32'd0);
        pc = 32'h40; #1;
        check("hi_pc.no_alias_alloc", {31'd0, pTaken}, 32'd0);
        pc = 32'h82; #1;
        check("misaligned.miss", {31'd0, pTaken}, 32'd0);

`ifdef BP_STATS_EN
        apply_reset();
        do_update(32'h10, 1, 16'h10, 1, 16'h10, 1, 1, "st1");
        do_update(32'h14, 1, 16'h20, 0, 16'h0,  1, 1, "st2");
        do_update(32'h10, 1, 16'h10, 1, 16'h10, 1, 1, "st3");
        do_update(32'h18, 0, 16'h0,  1, 16'h30, 1, 1, "st4");
        do_update(32'h10, 0, 16'h0,  0, 16'h0,  1, 1, "st5");
        #1;
        check("stats.branches",    stat_branches,    32'd5);
        check("stats.mispredicts", stat_mispredicts, 32'd2);
`endif

        for (int n = 0; n < 300; n++) begin
            rp = {16'h0, 6'($urandom_range(0, 3)) << 4 | 10'($urandom_range(0, 0)), 4'($urandom_range(0, 15)), 2'b00};
            rp[7:6] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) rp[31:16] = 16'h0001;
            rt = 16'($urandom);
            do_update(rp, 1'($urandom_range(0, 1)), rt, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? rt : 16'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), "rnd");
            pc = {16'h0, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 4) == 0 ? 2 : 0)};
            #1;
            check_lookup("rnd.look");
`ifdef BP_STATS_EN
            check("rnd.branches",    stat_branches,    m_branches[31:0]);
            check("rnd.mispredicts", stat_mispredicts, m_mispredicts[31:0]);
`endif
            if (n == 150) begin
                apply_reset();
                for (int j = 0; j < 16; j++) begin
                    pc = {16'h0, 10'($urandom_range(0, 3)), 4'(j), 2'b00};
                    #1;
                    check("midrst.miss", {31'd0, pTaken}, 32'd0);
                end
`ifdef BP_STATS_EN
                check("midrst.branches",    stat_branches,    32'd0);
                check("midrst.mispredicts", stat_mispredicts, 32'd0);
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor: the producer side of the PC's prediction inputs.
- Each cycle it looks up the current fetch PC and drives pTaken/pTarget back to the program counter in the same cycle.
- It is trained by branch resolutions from EX.
- Direct-mapped BTB with a 2-bit saturating counter per entry; state advances only when the pipeline advances (IF_DONE && MEM_DONE).

Parameters:
- IDX_W, 4: index width; the table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 16-IDX_W-2: tag width; tag = pc[15:IDX_W+2].

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- IF_DONE  input  1  instruction fetch handshake complete.
- MEM_DONE  input  1  data memory handshake complete.
- pc  input  32  current fetch PC (PC register output).
- pTaken  output  1  predict taken for pc.
- pTarget  output  16  predicted target for pc.
- upd_valid  input  1  EX has a resolved branch/jump this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual direction.
- upd_target  input  16  actual target, low 16 bits.
- upd_pred_taken  input  1  prediction that was made for this instruction (carried down the pipe).
- upd_pred_target  input  16  predicted target that was carried down the pipe.
- mispredict  output  1  combinational; upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Entry fields: valid, tag[TAG_W], target[16], ctr[2].
- Reset (synchronous, rst high at posedge clk): all valid=0 and all ctr=2'b01. rst has priority over any pending update.
- Outputs during and immediately after reset: pTaken=0 and pTarget=16'd0. Since no entry is valid, pTaken is 0 for every pc.

Lookup (purely combinational, zero latency):
- hit = valid[idx] && tag[idx]==pc[15:IDX_W+2] && pc[31:16]==0 && pc[1:0]==0.
- pTaken = hit && ctr[idx][1].
- pTarget = hit ? target[idx] : 16'd0.

Update (at posedge clk), when upd_valid && IF_DONE && MEM_DONE && !rst; otherwise no state change, including while either DONE is low:
- Index and tag are taken from upd_pc. An upd_pc with bits [31:16] != 0 is ignored (no allocation, no update).
- Hit, taken: ctr saturating increment (11 stays 11); target <= upd_target.
- Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
- Miss, taken: allocate, overwriting any existing entry. Set valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
- Miss, not taken: no allocation, table unchanged.

Boundary conditions:
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents. There is no write-to-read bypass.
- Aliasing: different PCs with the same index and different tags evict each other on taken allocation.
- Flush: the predictor ignores flush. The PC gives flush priority, and training arrives only via upd_*.

Optional Feature:
- Macro: BP_STATS_EN.
- With BP_STATS_EN defined: adds outputs stat_branches[32] and stat_mispredicts[32].
  - Both reset to 0.
  - On an accepted update (same qualification as a table update, excluding the upd_pc[31:16] filter), stat_branches increments. stat_mispredicts also increments when mispredict=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Without BP_STATS_EN: these ports and their logic do not exist. Table behaviour is identical either way.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_entry_t (packed struct: valid, tag, target, ctr);
  - ctr encoding constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - reset constant CTR_RST=CTR_WNT.
- One sub-module, sat_counter2: combinational next-state for a 2-bit saturating counter (inputs ctr, inc; output ctr_nxt). Instantiated once on the update path.

Test Plan:
- Reset then pc=32'h40 -> pTaken=0, pTarget=0; mispredict=0 when upd_valid=0.
- Update upd_pc=32'h40, taken=1, target=16'h100 (DONEs high), then pc=32'h40 -> pTaken=1, pTarget=16'h100 (ctr=10).
- Two not-taken updates on 32'h40 -> first drops ctr to 01, pTaken=0, pTarget=16'h100; second drops ctr to 00. Then three taken updates -> ctr reaches 11; a fourth taken update keeps it at 11.
- Taken update at 32'h80 (same index as 32'h40 for IDX_W=4, different tag) -> entry evicted: pc=32'h40 gives pTaken=0, pc=32'h80 hits.
- upd_valid=1 with IF_DONE=0 or MEM_DONE=0 -> table unchanged. upd_pc=32'h0001_0040 taken -> no allocation. pc=32'h0001_0040 -> pTaken=0.
- With BP_STATS_EN: 5 updates, 2 with upd_pred_taken!=upd_taken -> stat_branches=5, stat_mispredicts=2. rst mid-run -> both 0 and all lookups miss.
